// File: rtl/interrupt_sequencer.sv
// Multi-source interrupt entry sequencer: edge-latched requests, fixed-priority selection,
// pipeline drain, stacking of resume PC and flags, and redirect of fetch to a per-source vector.
module interrupt_sequencer #(
  parameter int unsigned NUM_IRQ      = 4,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned FLAG_WIDTH   = 3,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned VEC_BASE     = 0,
  parameter int unsigned VEC_STRIDE   = 2,
  localparam int unsigned IdW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    mask_wdata,
  input  logic [PC_WIDTH-1:0]   resume_pc,
  input  logic [FLAG_WIDTH-1:0] flags,
  input  logic                  branch_in_flight,
  input  logic                  push_ack,
  input  logic                  rti_done,
  output logic                  fetch_stall,
  output logic                  flush_decode,
  output logic                  push_valid,
  output logic [15:0]           push_data,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_vector,
  output logic                  irq_active,
  output logic [IdW-1:0]        irq_id
);

  localparam int unsigned NumPc    = PC_WIDTH / 16;
  localparam int unsigned NumWords = NumPc + 1;
  localparam int unsigned WordW    = $clog2(NumWords);

  typedef enum logic [2:0] {StIdle, StDrain, StPush, StVector, StService} state_e;

  state_e                state_q, state_d;
  logic [NUM_IRQ-1:0]    pending_q, pending_d;
  logic [NUM_IRQ-1:0]    mask_q, mask_d;
  logic [NUM_IRQ-1:0]    irq_prev_q;
  logic [IdW-1:0]        id_q, id_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WordW-1:0]      word_q, word_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;

  logic fetch_stall_q, fetch_stall_d;
  logic flush_decode_q, flush_decode_d;
  logic push_valid_q, push_valid_d;
  logic pc_load_q, pc_load_d;
  logic irq_active_q, irq_active_d;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;
  logic [IdW-1:0]     winner;

  // Lowest set index wins: scan downwards so the last hit is the highest priority.
  always_comb begin
    eligible = pending_q & mask_q;
    winner   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IdW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    clr     = '0;

    unique case (state_q)
      StIdle: begin
        if (|eligible && !branch_in_flight) begin
          state_d     = StDrain;
          id_d        = winner;
          clr[winner] = 1'b1;
          cnt_d       = 4'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        if (cnt_q == 4'd0) begin
          pc_d    = resume_pc;
          flags_d = flags;
          word_d  = '0;
          state_d = StPush;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPush: begin
        if (push_ack) begin
          if (word_q == WordW'(NumWords - 1)) state_d = StVector;
          else                                word_d  = word_q + WordW'(1);
        end
      end
      StVector:  state_d = StService;
      StService: if (rti_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // A new edge on a bit being cleared this cycle keeps it pending.
    pending_d = (pending_q & ~clr) | (irq & ~irq_prev_q);
    mask_d    = mask_we ? mask_wdata : mask_q;

    fetch_stall_d  = (state_d == StDrain) || (state_d == StPush);
    flush_decode_d = (state_d == StDrain);
    push_valid_d   = (state_d == StPush);
    pc_load_d      = (state_d == StVector);
    irq_active_d   = (state_d == StService);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      mask_q         <= '1;
      irq_prev_q     <= '0;
      id_q           <= '0;
      cnt_q          <= '0;
      word_q         <= '0;
      pc_q           <= '0;
      flags_q        <= '0;
      fetch_stall_q  <= 1'b0;
      flush_decode_q <= 1'b0;
      push_valid_q   <= 1'b0;
      pc_load_q      <= 1'b0;
      irq_active_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      mask_q         <= mask_d;
      irq_prev_q     <= irq;
      id_q           <= id_d;
      cnt_q          <= cnt_d;
      word_q         <= word_d;
      pc_q           <= pc_d;
      flags_q        <= flags_d;
      fetch_stall_q  <= fetch_stall_d;
      flush_decode_q <= flush_decode_d;
      push_valid_q   <= push_valid_d;
      pc_load_q      <= pc_load_d;
      irq_active_q   <= irq_active_d;
    end
  end

  // PC words go out most-significant first, followed by the zero-extended flags word.
  logic [15:0] pc_word;
  always_comb begin
    pc_word = '0;
    for (int i = 0; i < int'(NumPc); i++) begin
      if (word_q == WordW'(i)) pc_word = pc_q[(int'(NumPc) - 1 - i) * 16 +: 16];
    end
    if (!push_valid_q)                   push_data = '0;
    else if (word_q == WordW'(NumPc))    push_data = 16'(flags_q);
    else                                 push_data = pc_word;
  end

  logic [PC_WIDTH-1:0] vec_addr;
  assign vec_addr  = PC_WIDTH'(VEC_BASE) + PC_WIDTH'(id_q) * PC_WIDTH'(VEC_STRIDE);
  assign pc_vector = pc_load_q ? vec_addr : '0;

  assign fetch_stall  = fetch_stall_q;
  assign flush_decode = flush_decode_q;
  assign push_valid   = push_valid_q;
  assign pc_load      = pc_load_q;
  assign irq_active   = irq_active_q;
  assign irq_id       = id_q;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Parametrised multi-source interrupt entry sequencer that replaces the single interrupt line into the pipelined core. It latches NUM_IRQ edge-triggered requests, selects one by fixed priority, and drains the pipeline by stalling fetch and flushing decode. It then pushes the resume PC and flags to the stack through a valid/ack handshake with the memory stage and redirects fetch to a per-source vector. It sits beside fetch/decode and drives the PC-load and stall/flush controls.

Parameters:
NUM_IRQ, 4, number of interrupt sources (1..16); index 0 is highest priority.
PC_WIDTH, 32, PC width; must be a multiple of 16.
FLAG_WIDTH, 3, flag register width; zero-extended to 16 bits when pushed.
DRAIN_CYCLES, 3, cycles fetch is stalled so in-flight instructions retire (1..15).
VEC_BASE, 0, vector address of source 0.
VEC_STRIDE, 2, address distance between consecutive vectors.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
irq  in  NUM_IRQ  request lines; a rising edge sets the pending bit.
mask_we  in  1  write enable for the mask register.
mask_wdata  in  NUM_IRQ  new mask; bit=1 enables the source.
resume_pc  in  PC_WIDTH  PC of the next instruction to execute after return.
flags  in  FLAG_WIDTH  current flag register.
branch_in_flight  in  1  a taken branch or jump is resolving in EX/MEM.
push_ack  in  1  memory stage has accepted push_data this cycle.
rti_done  in  1  one-cycle pulse; the return-from-interrupt has completed.
fetch_stall  out  1  freezes PC and the fetch/decode register.
flush_decode  out  1  inject a NOP into the decode register.
push_valid  out  1  push_data is valid.
push_data  out  16  word to push.
pc_load  out  1  load pc_vector into the PC.
pc_vector  out  PC_WIDTH  target vector address.
irq_active  out  1  a handler is in service.
irq_id  out  max(1,clog2(NUM_IRQ))  index of the source being serviced.

Behaviour:
- Reset (async): state IDLE; pending=0; mask=all 1s; irq edge history=0; captured PC/flags=0; every output 0.
- Edge detect: pending[i] is set when irq[i]=1 and the irq[i] value registered last cycle was 0. When a bit is set and cleared in the same cycle, set wins.
- eligible = pending & mask. The winner is the lowest set index.
- A mask write takes effect the next cycle. Masked sources stay pending.
- IDLE: if eligible≠0 and branch_in_flight=0, go to DRAIN. Latch irq_id, clear that pending bit, and load the drain counter with DRAIN_CYCLES-1. If branch_in_flight=1, entry is deferred with no loss of the pending bit.
- DRAIN: fetch_stall=1, flush_decode=1. Decrement the counter each cycle. When the counter reaches 0, capture resume_pc and flags, then go to PUSH.
- PUSH: fetch_stall=1, push_valid=1. Send PC_WIDTH/16 PC words most-significant first, then the flags word {zero-extend, flags}.
  - push_data is held stable until push_ack. Advance one word per acked cycle; there are no bubbles when ack stays high.
  - Ack on the last word goes to VECTOR.
  - push_ack while push_valid=0 is ignored.
- VECTOR: single cycle. pc_load=1, pc_vector=VEC_BASE+irq_id*VEC_STRIDE (PC_WIDTH arithmetic, truncating), fetch_stall=0. Next state is SERVICE.
- SERVICE: irq_active=1; irq_id is held. No new entry (no nesting); new edges still set pending bits. rti_done goes to IDLE the next cycle. A pending request may then enter from IDLE no earlier than the cycle after that.
- rti_done outside SERVICE is ignored.
- Latency: irq edge at cycle 0 → pending at 1 → DRAIN at 2 → first push_valid at 2+DRAIN_CYCLES.
- Reset asserted mid-sequence aborts immediately to the reset state. A partial push is abandoned.
- Outputs are registered except push_data/pc_vector, which are muxed from registered state.

Test Plan:
- Single request, NUM_IRQ=4, defaults, push_ack tied 1: irq[2] rises, resume_pc=0x0000_1234, flags=3'b101 → DRAIN 3 cycles with fetch_stall=flush_decode=1. Pushes follow in order 0x0000, 0x1234, 0x0005. Then pc_load=1 with pc_vector=4, then irq_active=1 and irq_id=2.
- Priority and retention: irq[3] and irq[1] rise in the same cycle → source 1 is serviced (vector 2) and pending[3] stays set. After rti_done, source 3 is serviced (vector 6) without a new edge.
- Mask: mask_wdata=4'b1110, then irq[0] rises → no entry. Write mask=4'b1111 → entry for source 0 begins the cycle after mask is updated; vector=0.
- Backpressure: push_ack low for 2 cycles on the second word → push_data holds 0x1234 with push_valid=1. The sequence completes only after the ack, and the total words pushed is exactly 3.
- Deferral and no nesting: branch_in_flight=1 while irq[0] is pending → stays IDLE until it drops. During SERVICE, an irq[1] edge does not enter; it is taken after rti_done.
- Reset mid-PUSH: assert rst after the first ack → all outputs 0 asynchronously, pending=0, mask=all 1s. After release, the block is idle with no push resumed.
